// File: rtl/uart_bus_responder.sv
// UART bus responder: CPU strobe interface with a transmit holding/shift path
// and a receive buffer fed by a synchronized, mid-bit sampled rxd.
module uart_bus_responder #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrn,
    input  logic       rdn,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       frame_err,
    output logic       overrun
);
    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic             wrn_q, rdn_q, armed;
    logic             wr_accept, rd_release;
    logic [7:0]       thr, rbr;

    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [7:0]       tx_sh, tx_sh_n;
    logic             txd_n, tsre_n, tx_load;

    logic             rx_s1, rx_s2;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [7:0]       rx_sh, rx_sh_n;
    logic             rx_done, rx_bad;

    // armed blocks a write strobe that was already low when reset released
    assign wr_accept  = armed & wrn_q & ~wrn;
    assign rd_release = ~rdn_q & rdn;
    assign bus_oe     = ~rdn;
    assign bus_out    = rbr;

    // Transmit next-state: a full THR is loaded from IDLE or straight out of STOP
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_sh_n    = tx_sh;
        txd_n      = txd;
        tsre_n     = tsre;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                txd_n   = 1'b1;
                tx_load = ~tbre;
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                    txd_n      = tx_sh[0];
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                        tx_sh_n  = tx_sh >> 1;
                        txd_n    = tx_sh[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (!tbre) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tsre_n     = 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_sh_n    = thr;
            tx_state_n = TX_START;
            tx_cnt_n   = '0;
            txd_n      = 1'b0;
            tsre_n     = 1'b0;
        end
    end

    // Receive next-state: false-start check at half bit, then full-bit spacing
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    rx_done    = rx_s2;
                    rx_bad     = ~rx_s2;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // CPU strobes and transmit holding register
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrn_q <= 1'b1;
            rdn_q <= 1'b1;
            armed <= 1'b0;
            thr   <= '0;
            tbre  <= 1'b1;
        end else begin
            wrn_q <= wrn;
            rdn_q <= rdn;
            armed <= 1'b1;
            if (wr_accept && tbre) begin
                thr  <= bus_in;
                tbre <= 1'b0;
            end else if (tx_load) begin
                tbre <= 1'b1;
            end
        end
    end

    // Transmit state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            txd      <= 1'b1;
            tsre     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            txd      <= txd_n;
            tsre     <= tsre_n;
        end
    end

    // Receive state register and buffer; a new byte beats a same-edge read clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rbr        <= '0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_s1     <= rxd;
            rx_s2     <= rx_s1;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_idx    <= rx_idx_n;
            rx_sh     <= rx_sh_n;
            frame_err <= rx_bad;
            overrun   <= rx_done & data_ready & ~rd_release;
            if (rx_done) begin
                rbr        <= rx_sh;
                data_ready <= 1'b1;
            end else if (rd_release) begin
                data_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder: directed boundary cases plus random TX/RX
// traffic checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_uart_bus_responder;
    localparam int unsigned CPB = 16;

    logic       clk = 1'b0, rst = 1'b0, wrn = 1'b1, rdn = 1'b1, rxd = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       bus_oe, data_ready, tbre, tsre, txd, frame_err, overrun;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .data_ready(data_ready),
        .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_err = 0;
    int unsigned cyc = 0;

    // reference model of the receive side
    logic        m_dr = 1'b0;
    logic [7:0]  m_rbr = 8'h00;
    int unsigned m_ferr = 0, m_ovr = 0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned start;
    } frame_t;
    frame_t      tx_frames[$];
    int unsigned ferr_seen = 0, ovr_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // txd frame decoder sampling at bit mid-points, plus pulse counters
    initial begin
        bit          busy = 1'b0;
        int unsigned t = 0, start = 0, k;
        logic [7:0]  b = 8'h00;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_seen++;
            if (overrun === 1'b1) ovr_seen++;
            if (rst !== 1'b1) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (txd === 1'b0) begin
                    busy = 1'b1; t = 0; start = cyc;
                end
            end else begin
                t++;
                if (t >= CPB + CPB/2 && (t - CPB/2) % CPB == 0) begin
                    k = (t - CPB/2) / CPB;
                    if (k <= 8) begin
                        b = {txd, b[7:1]};
                    end else begin
                        tx_frames.push_back('{data: b, stop: txd, start: start});
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cpu_write(input logic [7:0] d);
        @(negedge clk); bus_in = d; wrn = 1'b0;
        @(negedge clk); wrn = 1'b1;
    endtask

    task automatic cpu_read(input logic [7:0] exp);
        @(negedge clk); rdn = 1'b0;
        #1 check("bus_oe", 32'(bus_oe), 1);
        @(negedge clk);
        check("bus_out", 32'(bus_out), 32'(exp));
        rdn = 1'b1;
        @(negedge clk);
        check("dr_clear", 32'(data_ready), 0);
        m_dr = 1'b0;
    endtask

    // called at a negedge; drives a full frame then leaves the line idle
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [7:0] s = d;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = s[0];
            s = s >> 1;
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic model_rx(input logic [7:0] d, input logic stop, input logic read_same_edge);
        if (stop) begin
            if (m_dr && !read_same_edge) m_ovr++;
            m_rbr = d;
            m_dr  = 1'b1;
        end else begin
            m_ferr++;
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_dr"},   32'(data_ready), 32'(m_dr));
        check({tag, "_rbr"},  32'(bus_out), 32'(m_rbr));
        check({tag, "_ferr"}, ferr_seen, m_ferr);
        check({tag, "_ovr"},  ovr_seen, m_ovr);
    endtask

    task automatic wait_tx(input logic [7:0] exp, output int unsigned start);
        int unsigned t = 0;
        frame_t f;
        start = 0;
        while (tx_frames.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (tx_frames.size() == 0) begin
            check("tx_timeout", 32'(tx_frames.size()), 1);
        end else begin
            f = tx_frames.pop_front();
            check("tx_byte", 32'(f.data), 32'(exp));
            check("tx_stop", 32'(f.stop), 1);
            start = f.start;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned w, s1, s2;
        logic [7:0]  tb, rb;
        logic        st;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_txd",  32'(txd), 1);
        check("rst_tbre", 32'(tbre), 1);
        check("rst_tsre", 32'(tsre), 1);
        check("rst_dr",   32'(data_ready), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr",  32'(overrun), 0);
        check("rst_rbr",  32'(bus_out), 0);
        check("rst_oe",   32'(bus_oe), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single byte 0x55 with exact timing
        cpu_write(8'h55);
        w = cyc;
        check("w55_tbre_lo", 32'(tbre), 0);
        @(negedge clk);
        check("w55_tbre_hi", 32'(tbre), 1);
        check("w55_tsre_lo", 32'(tsre), 0);
        check("w55_txd_start", 32'(txd), 0);
        wait_tx(8'h55, s1);
        check("w55_start_cyc", s1, w + 1);
        repeat (s1 + 159 - cyc) @(negedge clk);
        check("w55_tsre_159", 32'(tsre), 0);
        @(negedge clk);
        check("w55_tsre_160", 32'(tsre), 1);
        check("w55_txd_idle", 32'(txd), 1);

        // back-to-back frames and a dropped third write
        cpu_write(8'hA3);
        repeat (40) @(negedge clk);
        cpu_write(8'h0F);
        check("q_tbre", 32'(tbre), 0);
        cpu_write(8'h77);
        wait_tx(8'hA3, s1);
        wait_tx(8'h0F, s2);
        check("q_no_gap", s2, s1 + 160);
        repeat (200) @(negedge clk);
        check("q_dropped", 32'(tx_frames.size()), 0);
        check("q_tsre", 32'(tsre), 1);

        // receive 0xC6 with data_ready timing at the stop mid-point
        @(negedge clk);
        fork
            send_rx(8'hC6, 1'b1);
            begin
                repeat (150) @(negedge clk);
                check("rx_dr_early", 32'(data_ready), 0);
                repeat (10) @(negedge clk);
                check("rx_dr_set", 32'(data_ready), 1);
                check("rx_rbr_c6", 32'(bus_out), 'hC6);
            end
        join
        model_rx(8'hC6, 1'b1, 1'b0);
        check_rx("c6");
        cpu_read(8'hC6);

        // false start, then a good frame proves RX went back to idle
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check_rx("false_start");
        @(negedge clk);
        send_rx(8'h81, 1'b1);
        model_rx(8'h81, 1'b1, 1'b0);
        check_rx("after_false");
        cpu_read(8'h81);

        // framing error, then overrun
        @(negedge clk);
        send_rx(8'h3C, 1'b0);
        model_rx(8'h3C, 1'b0, 1'b0);
        check_rx("ferr");
        @(negedge clk);
        send_rx(8'h11, 1'b1);
        model_rx(8'h11, 1'b1, 1'b0);
        @(negedge clk);
        send_rx(8'h22, 1'b1);
        model_rx(8'h22, 1'b1, 1'b0);
        check_rx("ovr");

        // read release on the same edge a byte completes: new byte wins
        @(negedge clk);
        fork
            send_rx(8'h5E, 1'b1);
            begin
                repeat (153) @(negedge clk);
                rdn = 1'b0;
                @(negedge clk);
                rdn = 1'b1;
            end
        join
        model_rx(8'h5E, 1'b1, 1'b1);
        check_rx("coincide");
        cpu_read(8'h5E);

        // random concurrent traffic
        for (int i = 0; i < 10; i++) begin
            tb = 8'($urandom);
            rb = 8'($urandom);
            st = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            fork
                cpu_write(tb);
                send_rx(rb, st);
            join
            model_rx(rb, st, 1'b0);
            check_rx("rnd_rx");
            wait_tx(tb, s1);
            if ($urandom_range(1, 0) == 1) cpu_read(m_rbr);
        end

        // reset mid-frame with the write strobe held low across release
        repeat (20) @(negedge clk);
        cpu_write(8'hE7);
        repeat (50) @(negedge clk);
        rst = 1'b0;
        wrn = 1'b0;
        bus_in = 8'h99;
        @(negedge clk);
        check("mrst_txd",  32'(txd), 1);
        check("mrst_tbre", 32'(tbre), 1);
        check("mrst_tsre", 32'(tsre), 1);
        check("mrst_dr",   32'(data_ready), 0);
        check("mrst_rbr",  32'(bus_out), 0);
        m_dr = 1'b0;
        m_rbr = 8'h00;
        tx_frames.delete();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        wrn = 1'b1;
        repeat (30) @(negedge clk);
        check("mrst_no_wr_tsre", 32'(tsre), 1);
        check("mrst_no_wr_tbre", 32'(tbre), 1);
        repeat (170) @(negedge clk);
        check("mrst_no_frame", 32'(tx_frames.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
